// File: rtl/twiddle_addr_gen.sv
// Twiddle ROM address generator for a radix-2 FFT stage sweep.
// Each accepted start walks the butterfly counter j across one stage. For every
// read it issues the ROM address, and it produces the matching operand pair
// indices one cycle later, in the same cycle as the ROM data.
module twiddle_addr_gen #(
    parameter int ADDR_WIDTH  = 9,
    parameter int STAGE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [STAGE_WIDTH-1:0] stage,
    input  logic                   stall,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  address,
    output logic                   tw_valid,
    output logic [ADDR_WIDTH:0]    pair_top,
    output logic [ADDR_WIDTH:0]    pair_bot,
    output logic                   last,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [STAGE_WIDTH-1:0] MAX_STAGE = STAGE_WIDTH'(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0]  LAST_J    = '1;
    localparam logic [ADDR_WIDTH-1:0]  LOW_ONES  = '1;
    localparam logic [ADDR_WIDTH:0]    ONE_WIDE  = (ADDR_WIDTH+1)'(1);

    state_t                   state;
    state_t                   next_state;
    logic [ADDR_WIDTH-1:0]    j;
    logic [STAGE_WIDTH-1:0]   s;
    logic                     accept;
    logic                     reject;
    logic [ADDR_WIDTH-1:0]    mask;
    logic [ADDR_WIDTH-1:0]    k;
    logic [ADDR_WIDTH-1:0]    group_bits;
    logic [ADDR_WIDTH:0]      span;
    logic [ADDR_WIDTH:0]      top_calc;
    logic [ADDR_WIDTH:0]      bot_calc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode and the per-state control strobes
    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (stage <= MAX_STAGE) begin
                        accept     = 1'b1;
                        next_state = RUN;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            RUN: begin
                busy  = 1'b1;
                rd_en = !stall;
                if (!stall && j == LAST_J) next_state = FLUSH;
            end
            FLUSH: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Index arithmetic: span = 2^(ADDR_WIDTH-s), so j splits into low bits k and
    // high bits g by a mask. pair_top = g*2*span + k is the high bits shifted up
    // one place. Bit (ADDR_WIDTH-s) of pair_top is always 0, so adding span is an OR.
    always_comb begin
        mask       = LOW_ONES >> s;
        k          = j & mask;
        group_bits = j & ~mask;
        span       = ONE_WIDE << (MAX_STAGE - s);
        top_calc   = {group_bits, 1'b0} | {1'b0, k};
        bot_calc   = top_calc | span;
        address    = (state == RUN) ? (k << s) : '0;
    end

    // Butterfly counter and latched stage; j parks on the last index instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            j <= '0;
            s <= '0;
        end else if (accept) begin
            j <= '0;
            s <= stage;
        end else if (rd_en && j != LAST_J) begin
            j <= j + 1'b1;
        end
    end

    // One-cycle pipeline that lines up the pair indices with the ROM read data
    always_ff @(posedge clk) begin
        if (rst) begin
            tw_valid <= 1'b0;
            pair_top <= '0;
            pair_bot <= '0;
            last     <= 1'b0;
            err      <= 1'b0;
        end else begin
            tw_valid <= rd_en;
            pair_top <= rd_en ? top_calc : '0;
            pair_bot <= rd_en ? bot_calc : '0;
            last     <= rd_en && (j == LAST_J);
            err      <= reject;
        end
    end

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Self-checking bench for twiddle_addr_gen with ADDR_WIDTH=9. A negedge monitor
// records every read and every valid beat. Directed vectors and sequence checks
// then compare the recorded values against hand-computed expectations.
module tb_twiddle_addr_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] stage = '0;
    logic       stall = 1'b0;
    logic       rd_en;
    logic [8:0] address;
    logic       tw_valid;
    logic [9:0] pair_top;
    logic [9:0] pair_bot;
    logic       last;
    logic       busy;
    logic       done;
    logic       err;

    twiddle_addr_gen #(.ADDR_WIDTH(9), .STAGE_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stage(stage), .stall(stall),
        .rd_en(rd_en), .address(address), .tw_valid(tw_valid),
        .pair_top(pair_top), .pair_bot(pair_bot), .last(last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stage;
        int j;
        int addr;
        int top;
        int bot;
    } vec_t;

    vec_t vecs[14];

    int checks = 0;
    int errors = 0;
    int edge_count = 0;
    int base = 0;
    bit mon_on = 1'b0;

    int rd_addr[1024];
    int rd_cyc[1024];
    int tw_top[1024];
    int tw_bot[1024];
    int tw_cyc[1024];
    int n_rd, n_tw, n_last, last_idx, done_cnt, done_cyc, n_stall_tw;

    // Counts active edges so that events can be given a cycle number relative to start
    always @(posedge clk) edge_count <= edge_count + 1;

    // Records reads, valid beats and done pulses away from the active edge
    always @(negedge clk) begin
        if (mon_on) begin
            if (rd_en === 1'b1) begin
                if (n_rd < 1024) begin
                    rd_addr[n_rd] = int'(address);
                    rd_cyc[n_rd]  = edge_count - base;
                end
                n_rd++;
            end
            if (tw_valid === 1'b1) begin
                if (n_tw < 1024) begin
                    tw_top[n_tw] = int'(pair_top);
                    tw_bot[n_tw] = int'(pair_bot);
                    tw_cyc[n_tw] = edge_count - base;
                end
                if (stall === 1'b1) n_stall_tw++;
                if (last === 1'b1) begin
                    n_last++;
                    last_idx = n_tw;
                end
                n_tw++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = edge_count - base;
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_mon();
        n_rd = 0; n_tw = 0; n_last = 0; last_idx = -1;
        done_cnt = 0; done_cyc = -1; n_stall_tw = 0;
    endtask

    // Raises start for one edge; afterwards the current cycle is cycle 1
    task automatic start_stage(input int st);
        @(posedge clk); #2;
        clear_mon();
        mon_on = 1'b1;
        start = 1'b1;
        stage = 4'(st);
        @(posedge clk); #2;
        start = 1'b0;
        stage = 4'd7;
        base  = edge_count - 1;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_reads(input int n, input int budget);
        for (int i = 0; i < budget && n_rd < n; i++) @(posedge clk);
    endtask

    // Compares every table vector belonging to the given stage with the recorded sweep
    task automatic check_vectors(input int st);
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].stage == st) begin
                check($sformatf("s%0d_j%0d_addr", st, vecs[i].j), rd_addr[vecs[i].j], vecs[i].addr);
                check($sformatf("s%0d_j%0d_top", st, vecs[i].j), tw_top[vecs[i].j], vecs[i].top);
                check($sformatf("s%0d_j%0d_bot", st, vecs[i].j), tw_bot[vecs[i].j], vecs[i].bot);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"},    int'(rd_en),    0);
        check({tag, "_address"},  int'(address),  0);
        check({tag, "_tw_valid"}, int'(tw_valid), 0);
        check({tag, "_pair_top"}, int'(pair_top), 0);
        check({tag, "_pair_bot"}, int'(pair_bot), 0);
        check({tag, "_last"},     int'(last),     0);
        check({tag, "_busy"},     int'(busy),     0);
        check({tag, "_done"},     int'(done),     0);
        check({tag, "_err"},      int'(err),      0);
    endtask

    initial begin
        int bad;
        int snap;

        vecs[0]  = '{0, 0,   0,   0,   512};
        vecs[1]  = '{0, 200, 200, 200, 712};
        vecs[2]  = '{0, 511, 511, 511, 1023};
        vecs[3]  = '{9, 0,   0,   0,   1};
        vecs[4]  = '{9, 255, 0,   510, 511};
        vecs[5]  = '{9, 511, 0,   1022, 1023};
        vecs[6]  = '{3, 0,   0,   0,   64};
        vecs[7]  = '{3, 63,  504, 63,  127};
        vecs[8]  = '{3, 70,  48,  134, 198};
        vecs[9]  = '{3, 511, 504, 959, 1023};
        vecs[10] = '{4, 100, 64,  196, 228};
        vecs[11] = '{4, 101, 80,  197, 229};
        vecs[12] = '{4, 0,   0,   0,   32};
        vecs[13] = '{4, 511, 496, 991, 1023};
        clear_mon();

        // Reset held for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_idle_outputs("reset");
        rst = 1'b0;

        // Stage 0 sweep with timing checks
        start_stage(0);
        check("s0_busy_cycle1", int'(busy), 1);
        wait_done(700);
        check("s0_reads", n_rd, 512);
        check("s0_beats", n_tw, 512);
        check("s0_first_rd_cycle", rd_cyc[0], 1);
        check("s0_last_rd_cycle", rd_cyc[511], 512);
        check("s0_first_tw_cycle", tw_cyc[0], 2);
        check("s0_last_tw_cycle", tw_cyc[511], 513);
        check("s0_last_count", n_last, 1);
        check("s0_last_index", last_idx, 511);
        check("s0_done_count", done_cnt, 1);
        check("s0_done_cycle", done_cyc, 514);
        check("s0_busy_after", int'(busy), 0);
        bad = 0;
        for (int n = 0; n < 512; n++)
            if (rd_addr[n] != n || tw_top[n] != n || tw_bot[n] != n + 512) bad++;
        check("s0_all_beats_bad", bad, 0);
        check_vectors(0);

        // Stage 9 sweep; a second start during RUN must be ignored
        start_stage(9);
        repeat (20) @(posedge clk);
        #2; start = 1'b1; stage = 4'd3;
        @(posedge clk); #2; start = 1'b0;
        wait_done(700);
        check("s9_reads", n_rd, 512);
        check("s9_beats", n_tw, 512);
        check("s9_done_count", done_cnt, 1);
        bad = 0;
        for (int n = 0; n < 512; n++)
            if (rd_addr[n] != 0 || tw_top[n] != 2 * n || tw_bot[n] != 2 * n + 1) bad++;
        check("s9_all_beats_bad", bad, 0);
        check_vectors(9);

        // Stage 3 sweep
        start_stage(3);
        wait_done(700);
        check("s3_reads", n_rd, 512);
        check("s3_last_index", last_idx, 511);
        check_vectors(3);

        // Stage 4 with a five-cycle stall right after j=100 is issued
        start_stage(4);
        wait_reads(101, 700);
        check("s4_reach_j100", n_rd, 101);
        #2; stall = 1'b1;
        repeat (5) @(posedge clk);
        #2; stall = 1'b0;
        wait_done(700);
        check("s4_beats_during_stall", n_stall_tw, 1);
        check("s4_stall_gap", rd_cyc[101] - rd_cyc[100], 6);
        check("s4_reads", n_rd, 512);
        check("s4_beats", n_tw, 512);
        bad = 0;
        for (int n = 0; n < 512; n++)
            if (tw_top[n] != (n / 32) * 64 + (n % 32) || tw_bot[n] != (n / 32) * 64 + (n % 32) + 32) bad++;
        check("s4_order_bad", bad, 0);
        check_vectors(4);

        // Illegal stage: err pulse, no sweep
        start_stage(10);
        check("err_pulse", int'(err), 1);
        check("err_busy", int'(busy), 0);
        @(posedge clk); #2;
        check("err_cleared", int'(err), 0);
        repeat (3) @(posedge clk);
        check("err_no_reads", n_rd, 0);

        // Reset in the middle of a sweep, then a clean restart
        start_stage(0);
        wait_reads(200, 700);
        #2; rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check_idle_outputs("midrst");
        snap = n_tw;
        repeat (4) @(posedge clk);
        check("midrst_no_beats", n_tw - snap, 0);
        check("midrst_no_done", done_cnt, 0);
        start_stage(0);
        wait_done(700);
        check("restart_reads", n_rd, 512);
        check("restart_first_addr", rd_addr[0], 0);
        check("restart_first_top", tw_top[0], 0);
        check("restart_done_cycle", done_cyc, 514);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
